rr_arb_apb_master: RTL and testbench

RR_ARB_APB_MASTER -- requirements
Module: rr_arb_apb_master

---
 rtl/rr_arb_apb_master.sv | 149 ++++++++++++++
 tb/tb_rr_arb_apb_master.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_apb_master.sv
// Purpose : round-robin arbiter over 4 request FIFOs feeding a single APB master port.
// Latency : pop at N, SETUP at N+1, ACCESS from N+2, completion strobe one cycle after pready.
// Backpressure: pops only in IDLE; ACCESS stretches on pready=0, so no FIFO is popped until the transfer ends.
//
// Ports:
//   clk, reset (async, active-low)
//   empty_in / pop_out                      : per-FIFO empty flags in, one-hot pop strobe out
//   req_addr_in / req_wdata_in / req_write_in: FIFO heads, 32-bit slice per FIFO, sampled in the pop cycle
//   paddr, psel, penable, pwrite, pwdata,
//   pready, prdata, pslverr                 : APB master interface
//   rsp_valid_out, rsp_id_out,
//   rsp_rdata_out, rsp_err_out              : one-cycle completion report
// Optional build macro ARB_TIMEOUT_EN: abort an ACCESS phase after TIMEOUT_CYC cycles
// without pready and report it as an error completion.
module rr_arb_apb_master #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     empty_in,
  output logic [NUM_REQ-1:0]     pop_out,
  input  logic [32*NUM_REQ-1:0]  req_addr_in,
  input  logic [32*NUM_REQ-1:0]  req_wdata_in,
  input  logic [NUM_REQ-1:0]     req_write_in,
  output logic [31:0]            paddr,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [31:0]            pwdata,
  input  logic                   pready,
  input  logic [31:0]            prdata,
  input  logic                   pslverr,
  output logic                   rsp_valid_out,
  output logic [1:0]             rsp_id_out,
  output logic [31:0]            rsp_rdata_out,
  output logic                   rsp_err_out
);

  // The pointer/id widths below are hard-wired for four requesters.
  if (NUM_REQ != 4 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("rr_arb_apb_master: NUM_REQ must be 4 and TIMEOUT_CYC must be >= 1");
  end

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETUP  = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;

  logic [1:0] state;
  logic [1:0] ptr;      // round-robin priority pointer: first index searched
  logic [1:0] cur_id;   // requester owning the transfer in flight
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       grant;
  logic       to_hit;   // ACCESS phase abandoned this cycle

  // Rotating search from ptr; the 2-bit add wraps naturally modulo 4.
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && !empty_in[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Only IDLE may grant, so empty_in activity during a transfer has no effect.
  assign grant   = (state == IDLE) && found;
  assign pop_out = grant ? (4'b0001 << win) : 4'b0000;
  assign psel    = (state == SETUP) || (state == ACCESS);
  assign penable = (state == ACCESS);

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  // Counts ACCESS cycles that ended without pready; restarted on every grant.
  logic [TO_W-1:0] to_cnt;

  assign to_hit = (state == ACCESS) && !pready && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (grant) begin
      to_cnt <= '0;
    end else if ((state == ACCESS) && !pready && !to_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ptr           <= 2'd0;
      cur_id        <= 2'd0;
      paddr         <= 32'd0;
      pwdata        <= 32'd0;
      pwrite        <= 1'b0;
      rsp_valid_out <= 1'b0;
      rsp_id_out    <= 2'd0;
      rsp_rdata_out <= 32'd0;
      rsp_err_out   <= 1'b0;
    end else begin
      rsp_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state  <= SETUP;
            ptr    <= win + 2'd1;
            cur_id <= win;
            paddr  <= req_addr_in[{win, 5'd0} +: 32];
            pwdata <= req_wdata_in[{win, 5'd0} +: 32];
            pwrite <= req_write_in[win];
          end
        end
        SETUP: begin
          state <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            state         <= IDLE;
            rsp_valid_out <= 1'b1;
            rsp_id_out    <= cur_id;
            rsp_rdata_out <= pwrite ? 32'd0 : prdata;
            rsp_err_out   <= pslverr;
          end else if (to_hit) begin
            state         <= IDLE;
            rsp_valid_out <= 1'b1;
            rsp_id_out    <= cur_id;
            rsp_rdata_out <= 32'd0;
            rsp_err_out   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_apb_master.sv
`timescale 1ns/1ps
module tb_rr_arb_apb_master;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   empty_in = 4'hF;
  logic [3:0]   pop_out;
  logic [127:0] req_addr_in = '0;
  logic [127:0] req_wdata_in = '0;
  logic [3:0]   req_write_in = '0;
  logic [31:0]  paddr;
  logic         psel, penable, pwrite;
  logic [31:0]  pwdata;
  logic         pready = 1'b1;
  logic [31:0]  prdata = '0;
  logic         pslverr = 1'b0;
  logic         rsp_valid_out;
  logic [1:0]   rsp_id_out;
  logic [31:0]  rsp_rdata_out;
  logic         rsp_err_out;

  rr_arb_apb_master #(.NUM_REQ(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .empty_in(empty_in), .pop_out(pop_out),
    .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in), .req_write_in(req_write_in),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .rsp_valid_out(rsp_valid_out), .rsp_id_out(rsp_id_out),
    .rsp_rdata_out(rsp_rdata_out), .rsp_err_out(rsp_err_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observation logs built from what the DUT actually did.
  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    logic        psel;
  } rsp_t;
  int   grant_log[$];
  int   pop_raw_log[$];
  int   pop_cyc_log[$];
  rsp_t rsp_log[$];
  int   pen_cnt = 0;

  // Reference model: a transfer is described by how many cycles ago it was
  // granted (age 1 = SETUP cycle, age >= 2 = ACCESS cycles).
  bit          m_busy = 0;
  int          m_age = 0;
  int          m_p = 0;
  int          m_w;
  int          m_id = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        m_write = 1'b0;
  bit          m_rsp = 0;
  int          m_rid = 0;
  logic [31:0] m_rdata = '0;
  logic        m_rerr = 1'b0;
  logic [3:0]  m_pop;
  int          d_idx;
  rsp_t        r;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_pop", 32'(pop_out), 32'd0);
      chk("rst_psel", 32'(psel), 32'd0);
      chk("rst_penable", 32'(penable), 32'd0);
      chk("rst_pwrite", 32'(pwrite), 32'd0);
      chk("rst_paddr", paddr, 32'd0);
      chk("rst_pwdata", pwdata, 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id_out), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata_out, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err_out), 32'd0);
      m_busy = 0; m_age = 0; m_p = 0; m_rsp = 0;
    end else begin
      m_w = -1;
      if (!m_busy)
        for (int k = 0; k < 4; k++)
          if (m_w < 0 && !empty_in[(m_p + k) % 4]) m_w = (m_p + k) % 4;
      m_pop = 4'b0000;
      if (m_w >= 0) m_pop[m_w] = 1'b1;

      chk("pop_out", 32'(pop_out), 32'(m_pop));
      chk("psel", 32'(psel), 32'(m_busy));
      chk("penable", 32'(penable), 32'(m_busy && m_age >= 2));
      if (m_busy) begin
        chk("paddr", paddr, m_addr);
        chk("pwdata", pwdata, m_wdata);
        chk("pwrite", 32'(pwrite), 32'(m_write));
      end
      chk("rsp_valid", 32'(rsp_valid_out), 32'(m_rsp));
      if (m_rsp) begin
        chk("rsp_id", 32'(rsp_id_out), 32'(m_rid));
        chk("rsp_rdata", rsp_rdata_out, m_rdata);
        chk("rsp_err", 32'(rsp_err_out), 32'(m_rerr));
      end

      if (pop_out != 4'b0000) begin
        d_idx = -1;
        for (int k = 0; k < 4; k++) if (pop_out[k]) d_idx = k;
        grant_log.push_back(d_idx);
        pop_raw_log.push_back(int'(pop_out));
        pop_cyc_log.push_back(cyc);
      end
      if (penable) pen_cnt++;
      if (rsp_valid_out) begin
        r.id = int'(rsp_id_out); r.rdata = rsp_rdata_out; r.err = rsp_err_out;
        r.cyc = cyc; r.psel = psel;
        rsp_log.push_back(r);
      end

      // Advance the model to what must be visible after the coming edge.
      m_rsp = 0;
      if (m_busy) begin
        if (m_age >= 2 && pready) begin
          m_rsp = 1; m_rid = m_id; m_rerr = pslverr;
          m_rdata = m_write ? 32'd0 : prdata;
          m_busy = 0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_age - 1 == TO) begin
          m_rsp = 1; m_rid = m_id; m_rerr = 1'b1; m_rdata = 32'd0;
          m_busy = 0;
        end
`endif
        else m_age++;
      end else if (m_w >= 0) begin
        m_busy  = 1; m_age = 1; m_id = m_w;
        m_addr  = req_addr_in[32*m_w +: 32];
        m_wdata = req_wdata_in[32*m_w +: 32];
        m_write = req_write_in[m_w];
        m_p     = (m_w + 1) % 4;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    grant_log.delete(); pop_raw_log.delete(); pop_cyc_log.delete();
    rsp_log.delete(); pen_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    empty_in = 4'hF; pready = 1'b1; pslverr = 1'b0; prdata = '0;
    step(2);
    reset = 1'b1;
    clear_logs();
  endtask

  task automatic wait_grants(input int n, input int budget);
    int t = 0;
    while (grant_log.size() < n && t < budget) begin
      step(1);
      t++;
    end
    if (grant_log.size() < n) chk("wait_grants_timeout", 32'(grant_log.size()), 32'(n));
  endtask

  task automatic wait_rsps(input int n, input int budget);
    int t = 0;
    while (rsp_log.size() < n && t < budget) begin
      step(1);
      t++;
    end
    if (rsp_log.size() < n) chk("wait_rsps_timeout", 32'(rsp_log.size()), 32'(n));
  endtask

  int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    // Reset held over a couple of edges; the model checks reset values.
    step(3);
    reset = 1'b1;
    clear_logs();

    // Single write from FIFO 0.
    req_write_in = 4'b0001;
    req_addr_in[31:0]  = 32'h0000_0100;
    req_wdata_in[31:0] = 32'hDEAD_BEEF;
    pready = 1'b1;
    empty_in = 4'b1110;
    wait_grants(1, 10);
    empty_in = 4'hF;
    wait_rsps(1, 10);
    step(2);
    chk("w0_pop_cycles", 32'(pop_raw_log.size()), 32'd1);
    chk("w0_pop_onehot", 32'(pop_raw_log[0]), 32'h1);
    chk("w0_rsp_id", 32'(rsp_log[0].id), 32'd0);
    chk("w0_rsp_err", 32'(rsp_log[0].err), 32'd0);
    chk("w0_rsp_rdata", rsp_log[0].rdata, 32'd0);
    chk("w0_latency", 32'(rsp_log[0].cyc - pop_cyc_log[0]), 32'd3);

    // All FIFOs busy: rotation 0..3 twice.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_addr_in[32*i +: 32]  = 32'h1000 + 32'(i);
      req_wdata_in[32*i +: 32] = $urandom;
    end
    req_write_in = 4'b1010;
    empty_in = 4'b0000;
    wait_grants(8, 40);
    empty_in = 4'hF;
    wait_rsps(8, 20);
    for (int i = 0; i < 8; i++) chk("rr_order", 32'(grant_log[i]), 32'(exp_order[i]));
    chk("rr_back_to_back", 32'(pop_cyc_log[1] - pop_cyc_log[0]), 32'd3);

    // Read from FIFO 2 with three wait states and a slave error.
    do_reset();
    req_write_in = 4'b0000;
    req_addr_in[95:64] = 32'h0000_002C;
    pready = 1'b0;
    empty_in = 4'b1011;
    wait_grants(1, 10);
    empty_in = 4'hF;
    step(4);
    pready = 1'b1; prdata = 32'h1234_5678; pslverr = 1'b1;
    wait_rsps(1, 10);
    pslverr = 1'b0; prdata = '0;
    step(1);
    chk("rd2_penable_cycles", 32'(pen_cnt), 32'd4);
    chk("rd2_rsp_id", 32'(rsp_log[0].id), 32'd2);
    chk("rd2_rsp_rdata", rsp_log[0].rdata, 32'h1234_5678);
    chk("rd2_rsp_err", 32'(rsp_log[0].err), 32'd1);

    // Grant 3 then only FIFO 1: pointer wraps to 0 and finds 1.
    do_reset();
    empty_in = 4'b0111;
    wait_grants(1, 10);
    empty_in = 4'hF;
    wait_rsps(1, 10);
    empty_in = 4'b1101;
    wait_grants(2, 10);
    empty_in = 4'hF;
    wait_rsps(2, 10);
    chk("wrap_first", 32'(grant_log[0]), 32'd3);
    chk("wrap_second", 32'(grant_log[1]), 32'd1);

    // Reset in the middle of ACCESS.
    do_reset();
    pready = 1'b0;
    empty_in = 4'b1011;
    wait_grants(1, 10);
    empty_in = 4'hF;
    step(3);
    chk("pre_rst_penable", 32'(penable), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_psel", 32'(psel), 32'd0);
    chk("async_rst_penable", 32'(penable), 32'd0);
    step(2);
    reset = 1'b1;
    pready = 1'b1;
    step(3);
    chk("rst_abort_no_rsp", 32'(rsp_log.size()), 32'd0);
    clear_logs();
    empty_in = 4'b0101;
    wait_grants(1, 10);
    empty_in = 4'hF;
    wait_rsps(1, 10);
    chk("post_rst_grant", 32'(grant_log[0]), 32'd1);

    // Completer that never answers.
    do_reset();
    pready = 1'b0;
    empty_in = 4'b1110;
    wait_grants(1, 10);
    empty_in = 4'hF;
`ifdef ARB_TIMEOUT_EN
    wait_rsps(1, 40);
    step(1);
    chk("to_rsp_err", 32'(rsp_log[0].err), 32'd1);
    chk("to_rsp_rdata", rsp_log[0].rdata, 32'd0);
    chk("to_psel_low", 32'(rsp_log[0].psel), 32'd0);
    chk("to_latency", 32'(rsp_log[0].cyc - pop_cyc_log[0]), 32'(TO + 2));
    chk("to_penable_cycles", 32'(pen_cnt), 32'(TO));
    pready = 1'b1;
`else
    step(TO + 8);
    chk("stall_no_rsp", 32'(rsp_log.size()), 32'd0);
    chk("stall_penable_cycles", 32'(pen_cnt), 32'(TO + 7));
    pready = 1'b1;
    wait_rsps(1, 10);
    chk("stall_rsp_err", 32'(rsp_log[0].err), 32'd0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      empty_in = 4'($urandom);
      for (int k = 0; k < 4; k++) begin
        req_addr_in[32*k +: 32]  = $urandom;
        req_wdata_in[32*k +: 32] = $urandom;
      end
      req_write_in = 4'($urandom);
      pready  = ($urandom_range(0, 2) != 0);
      prdata  = $urandom;
      pslverr = ($urandom_range(0, 3) == 0);
      step(1);
    end
    empty_in = 4'hF;
    pready = 1'b1;
    step(6);
    chk("rand_activity", 32'(grant_log.size() > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
